// File: rtl/tag_byte_streamer_if.sv
// Tag/byte bus between the tagging core, the PC instruction path and the FX2 bridge.
// master: the streamer side; slave: the bridge/core side.
interface tag_byte_streamer_if #(
  parameter int TAG_WIDTH = 32
);
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 tag_valid;
  logic [7:0]           fpga_word;
  logic                 fpga_word_availiable;
  logic                 fpga_word_accepted;
  logic [7:0]           pcinstruction;
  logic                 request_length;
  logic [15:0]          length;
  logic                 acq_enable;
  logic                 tag_overflow;

  modport master (
    input  tag_in, tag_valid, fpga_word_accepted, pcinstruction, request_length,
    output fpga_word, fpga_word_availiable, length, acq_enable, tag_overflow
  );

  modport slave (
    output tag_in, tag_valid, fpga_word_accepted, pcinstruction, request_length,
    input  fpga_word, fpga_word_availiable, length, acq_enable, tag_overflow
  );
endinterface

// File: rtl/tag_byte_streamer.sv
// Buffers 32-bit time tags and streams them MSB-first as bytes to the FX2 bridge.
// Latency: tag strobe to first byte is 2 cycles; bytes held until the bridge accepts them.
module tag_byte_streamer #(
  parameter int TAG_WIDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                i_fx2_clk,
  input  logic                i_rst_n,
  tag_byte_streamer_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_B3,
    S_B2,
    S_B1,
    S_B0
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TAG_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [TAG_WIDTH-1:0] r_shift;
  logic [15:0]          r_cnt;
  logic [15:0]          r_length;
  logic                 r_acq;
  logic                 r_ovf;

  logic                 w_toggle;
  logic                 w_flush;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_adv;
  logic                 w_accept;
  logic [15:0]          w_cnt_inc;

  assign w_toggle = (bus.pcinstruction != 8'd0) && bus.pcinstruction[5] &&
                    (bus.pcinstruction[3:0] == 4'h1);
  assign w_flush  = (bus.pcinstruction != 8'd0) && bus.pcinstruction[4] &&
                    (bus.pcinstruction[3:0] == 4'h2);

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Full is judged before any same-cycle pop, so a full FIFO drops even while draining.
  assign w_wr     = bus.tag_valid && r_acq && !w_full && !w_flush;
  assign w_drop   = bus.tag_valid && r_acq &&  w_full && !w_flush;

  assign w_accept  = bus.fpga_word_accepted && (r_state != S_EMPTY) && !w_flush;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    if (w_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_B3;
          end
        end
        S_B3: begin
          if (bus.fpga_word_accepted) begin
            w_adv       = 1'b1;
            w_state_nxt = S_B2;
          end
        end
        S_B2: begin
          if (bus.fpga_word_accepted) begin
            w_adv       = 1'b1;
            w_state_nxt = S_B1;
          end
        end
        S_B1: begin
          if (bus.fpga_word_accepted) begin
            w_adv       = 1'b1;
            w_state_nxt = S_B0;
          end
        end
        S_B0: begin
          if (bus.fpga_word_accepted) begin
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = S_B3;
            end else begin
              w_adv       = 1'b1;
              w_state_nxt = S_EMPTY;
            end
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_fx2_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Tag storage carries no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge i_fx2_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.tag_in;
    end
  end

  always_ff @(posedge i_fx2_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_shift  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_shift  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_shift  <= r_mem[r_rd_ptr[AW-1:0]];
      end else if (w_adv) begin
        r_shift  <= {r_shift[TAG_WIDTH-9:0], 8'd0};
      end
    end
  end

  always_ff @(posedge i_fx2_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acq <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_toggle) begin
        r_acq <= !r_acq;
      end
      if (w_flush) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // A length request folds in an accept from the same cycle; flush suppresses that accept.
  always_ff @(posedge i_fx2_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= 16'd0;
      r_length <= 16'd0;
    end else begin
      if (bus.request_length) begin
        r_length <= w_accept ? w_cnt_inc : r_cnt;
      end
      if (w_flush) begin
        r_cnt <= 16'd0;
      end else if (bus.request_length) begin
        r_cnt <= {15'd0, w_accept};
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign bus.fpga_word            = r_shift[TAG_WIDTH-1 -: 8];
  assign bus.fpga_word_availiable = (r_state != S_EMPTY);
  assign bus.length               = r_length;
  assign bus.acq_enable           = r_acq;
  assign bus.tag_overflow         = r_ovf;
endmodule

// File: doc/tag_byte_streamer.md
# tag_byte_streamer

Buffers 32-bit time tags from the tagging core and serializes them MSB-first into the byte-wide FPGA-side port of the FX2 USB bridge. It presents bytes with an available/accepted handshake and counts accepted bytes so the bridge can report packet length on request. It also decodes PC instruction bytes into acquisition-enable and flush controls. It is the FPGA-side partner of the FX2 bridge, running in the FX2 clock domain.

## Interface
- TAG_WIDTH, 32: tag width; fixed at 4 bytes.
- DEPTH, 16: tag FIFO depth; a power of two.
- FX2_CLK  in  1  FX2 interface clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TAG_IN  in  32  time tag.
- TAG_VALID  in  1  one-cycle strobe: TAG_IN is valid.
- FPGA_WORD  out  8  byte offered to the bridge; registered.
- FPGA_WORD_AVAILIABLE  out  1  FPGA_WORD is valid.
- FPGA_WORD_ACCEPTED  in  1  bridge consumed FPGA_WORD this cycle.
- PCINSTRUCTION  in  8  instruction byte; nonzero only in its single valid cycle.
- REQUEST_LENGTH  in  1  one-cycle strobe: latch the byte count.
- LENGTH  out  16  bytes accepted between the last two REQUEST_LENGTH strobes.
- ACQ_ENABLE  out  1  tags are accepted into the FIFO.
- TAG_OVERFLOW  out  1  sticky flag: at least one tag was dropped because the FIFO was full.

## Operation
- Reset values: FPGA_WORD=0, FPGA_WORD_AVAILIABLE=0, LENGTH=0, ACQ_ENABLE=0, TAG_OVERFLOW=0. The FIFO, shift register and byte counter are empty or zero.
- Instruction decode, evaluated only when PCINSTRUCTION≠0:
  - Bit 5 set with bits[3:0]=4'h1: toggle ACQ_ENABLE.
  - Bit 4 set with bits[3:0]=4'h2: FLUSH.
  - All other codes are ignored.
- FLUSH, applied at the next edge:
  - Empty the FIFO and the shift register; FPGA_WORD_AVAILIABLE=0.
  - Clear the byte counter and TAG_OVERFLOW.
  - LENGTH and ACQ_ENABLE are unchanged.
- FIFO write: occurs when TAG_VALID & ACQ_ENABLE & ~full & ~FLUSH.
  - TAG_VALID & ACQ_ENABLE while full drops the tag and sets TAG_OVERFLOW. "Full" is the value before any same-cycle read.
  - TAG_VALID with ACQ_ENABLE=0 is ignored and does not set overflow.
- Serializer states:
  - EMPTY: FPGA_WORD_AVAILIABLE=0. If the FIFO is non-empty, pop the head into the shift register and go to B3.
  - B3, B2, B1, B0: FPGA_WORD = tag[31:24], [23:16], [15:8], [7:0] respectively; FPGA_WORD_AVAILIABLE=1.
  - FPGA_WORD_ACCEPTED advances B3→B2→B1→B0.
  - ACCEPTED in B0: if the FIFO is non-empty, pop the next tag and go to B3 in the same edge; otherwise go to EMPTY.
  - FPGA_WORD_ACCEPTED while FPGA_WORD_AVAILIABLE=0 is ignored.
- Byte counter: 16 bits, increments on each valid accept and saturates at 16'hFFFF.
- REQUEST_LENGTH: LENGTH ← counter (including an accept in the same cycle); the counter clears to 0, or to 1 if an accept occurs in that cycle. LENGTH then holds until the next strobe.

## Timing
- Tag latency: TAG_VALID in cycle n with the pipeline empty gives FPGA_WORD_AVAILIABLE=1 and FPGA_WORD=tag[31:24] in cycle n+2.
- FPGA_WORD and FPGA_WORD_AVAILIABLE are registered. The bridge samples them combinationally in the same cycle it asserts ACCEPTED, so the next byte appears in the following cycle.
- Throughput: one byte per cycle under continuous ACCEPTED, with no bubble between tags while the FIFO is non-empty. A FIFO write in the same cycle as an EMPTY or B0 pop is visible to the pop one cycle later.
- Simultaneous FIFO read and write when not full: both occur and the occupancy is unchanged.
- FLUSH has priority over ACCEPTED, TAG_VALID and FIFO pop in the same cycle. REQUEST_LENGTH in the FLUSH cycle latches the pre-flush count.
- Pointers are log2(DEPTH)+1 bits. Full: MSBs differ and the lower bits are equal. Empty: pointers are equal. Wrap-around is silent.
- RST_N assertion mid-byte or mid-tag discards all state asynchronously; there is no partial-tag resumption.

## Test plan
- Reset, then toggle instruction 8'h21, then TAG_VALID with 32'hA1B2C3D4 and ACCEPTED held high → bytes A1, B2, C3, D4 on consecutive cycles, FPGA_WORD_AVAILIABLE first high 2 cycles after TAG_VALID, then 0.
- Three back-to-back tags with ACCEPTED held high → 12 contiguous bytes with no gap.
- ACQ_ENABLE=1, ACCEPTED held low, 17 tags written with DEPTH=16 → first tag in the shift register, 15 in the FIFO, and the 17th fills the FIFO. An 18th tag sets TAG_OVERFLOW=1 and is dropped. Draining yields exactly 17 tags in order.
- Accept 10 bytes, pulse REQUEST_LENGTH, accept 3, pulse again → LENGTH=10 after the first pulse and 3 after the second. A pulse coincident with an accept counts that byte into the latched value.
- Mid-tag (state B2) with a full FIFO, issue 8'h12 → FPGA_WORD_AVAILIABLE=0 next cycle, TAG_OVERFLOW=0, FIFO empty, LENGTH unchanged.
- Assert RST_N low during state B1 → all outputs reset immediately. After release, the toggle instruction is required again before any tags are accepted.
